// File: rtl/multi_channel_interval_timer_pkg.sv
// Shared register map, bit positions and helpers for the multi-channel interval timer.
package multi_channel_interval_timer_pkg;

  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_CONTROL  = 3'd1;
  localparam logic [2:0] REG_PERIOD   = 3'd2;
  localparam logic [2:0] REG_SNAPSHOT = 3'd3;
  localparam logic [2:0] REG_CAPTURE  = 3'd4;
  localparam logic [2:0] REG_PRESCALE = 3'd5;

  localparam int ST_TO  = 0;
  localparam int ST_RUN = 1;
  localparam int ST_CAP = 2;

  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;
  localparam int CTL_ICAP  = 4;
  localparam int CTL_CAPEN = 5;

  typedef struct packed {
    logic        wr;
    logic [2:0]  off;
    logic [31:0] wdata;
  } ch_req_t;

  function automatic int ch_addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit width_ok(input int w, input int lo, input int hi);
    return (w >= lo) && (w <= hi);
  endfunction

endpackage

// File: rtl/multi_channel_interval_timer_channel.sv
// One timer channel: prescaled down-counter, sticky TO/CAP flags, capture synchroniser, register file.
module timer_channel
  import multi_channel_interval_timer_pkg::*;
#(
  parameter int          CNT_W        = 32,
  parameter int          PRE_W        = 8,
  parameter logic [31:0] RESET_PERIOD = 32'h000124F7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  ch_req_t     req,
  input  logic        capture_in,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [CNT_W-1:0] RST_P = RESET_PERIOD[CNT_W-1:0];

  logic             run, to_f, cap_f, ito, cont, icap, capen;
  logic             force_reload, prev_zero;
  logic [CNT_W-1:0] period, counter, snapshot, capture;
  logic [PRE_W-1:0] prescale, pre_cnt;
  logic [2:0]       cap_pipe;

  logic wr_status, wr_ctrl, wr_period, wr_snap, wr_pre;
  logic start, stop, zero, tick, to_evt, cap_evt;

  assign wr_status = req.wr && (req.off == REG_STATUS);
  assign wr_ctrl   = req.wr && (req.off == REG_CONTROL);
  assign wr_period = req.wr && (req.off == REG_PERIOD);
  assign wr_snap   = req.wr && (req.off == REG_SNAPSHOT);
  assign wr_pre    = req.wr && (req.off == REG_PRESCALE);

  assign start   = wr_ctrl && req.wdata[CTL_START];
  assign stop    = wr_ctrl && req.wdata[CTL_STOP];
  assign zero    = (counter == '0);
  assign tick    = run && (pre_cnt == '0);
  assign to_evt  = zero && !prev_zero;
  // cap_pipe[1:0] is the synchroniser; cap_pipe[2] is the previous sample for edge detect
  assign cap_evt = capen && cap_pipe[1] && !cap_pipe[2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run          <= 1'b0;
      to_f         <= 1'b0;
      cap_f        <= 1'b0;
      {capen, icap, cont, ito} <= '0;
      force_reload <= 1'b0;
      prev_zero    <= (RST_P == '0);
      period       <= RST_P;
      counter      <= RST_P;
      snapshot     <= '0;
      capture      <= '0;
      prescale     <= '0;
      pre_cnt      <= '0;
      cap_pipe     <= '0;
    end else begin
      cap_pipe     <= {cap_pipe[1:0], capture_in};
      prev_zero    <= zero;
      force_reload <= wr_period || wr_pre;
      if (wr_period) period   <= req.wdata[CNT_W-1:0];
      if (wr_pre)    prescale <= req.wdata[PRE_W-1:0];
      if (wr_ctrl)
        {capen, icap, cont, ito} <= {req.wdata[CTL_CAPEN], req.wdata[CTL_ICAP],
                                     req.wdata[CTL_CONT], req.wdata[CTL_ITO]};
      if (wr_snap) snapshot <= counter;
      if (cap_evt) capture  <= counter;

      if (force_reload)      counter <= period;
      else if (tick)         counter <= zero ? period : counter - CNT_W'(1);

      if (force_reload || start || tick) pre_cnt <= prescale;
      else if (run)                      pre_cnt <= pre_cnt - PRE_W'(1);

      // a START in the same write as STOP, or racing a pending reload, keeps the channel running
      if (start)                                        run <= 1'b1;
      else if (stop || force_reload || (zero && !cont)) run <= 1'b0;

      if (to_evt)                             to_f <= 1'b1;
      else if (wr_status && req.wdata[ST_TO]) to_f <= 1'b0;

      if (cap_evt)                             cap_f <= 1'b1;
      else if (wr_status && req.wdata[ST_CAP]) cap_f <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    case (req.off)
      REG_STATUS: begin
        rdata[ST_TO]  = to_f;
        rdata[ST_RUN] = run;
        rdata[ST_CAP] = cap_f;
      end
      REG_CONTROL: begin
        rdata[CTL_ITO]   = ito;
        rdata[CTL_CONT]  = cont;
        rdata[CTL_ICAP]  = icap;
        rdata[CTL_CAPEN] = capen;
      end
      REG_PERIOD:   rdata[CNT_W-1:0] = period;
      REG_SNAPSHOT: rdata[CNT_W-1:0] = snapshot;
      REG_CAPTURE:  rdata[CNT_W-1:0] = capture;
      REG_PRESCALE: rdata[PRE_W-1:0] = prescale;
      default:      rdata = '0;
    endcase
  end

  assign irq = (to_f && ito) || (cap_f && icap);

endmodule

// File: rtl/multi_channel_interval_timer.sv
// Avalon-MM slave wrapping NUM_CH timer channels: address decode, registered read mux, irq combine.
module multi_channel_interval_timer
  import multi_channel_interval_timer_pkg::*;
#(
  parameter int          NUM_CH       = 4,
  parameter int          CNT_W        = 32,
  parameter int          PRE_W        = 8,
  parameter logic [31:0] RESET_PERIOD = 32'h000124F7,
  localparam int         CH_AW        = ch_addr_w(NUM_CH)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CH_AW+2:0]    address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  input  logic [NUM_CH-1:0]   capture_in,
  output logic [NUM_CH-1:0]   irq_vec,
  output logic                irq
);

  logic                         wr;
  logic [CH_AW-1:0]             ch_idx;
  logic [2:0]                   off;
  logic [NUM_CH-1:0][31:0]      ch_rdata;
  logic [31:0]                  rd_mux;

  assign wr     = chipselect && !write_n;
  assign ch_idx = address[CH_AW+2:3];
  assign off    = address[2:0];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ch_req_t req;
    assign req.wr    = wr && (ch_idx == CH_AW'(g));
    assign req.off   = off;
    assign req.wdata = writedata;

    timer_channel #(
      .CNT_W        (CNT_W),
      .PRE_W        (PRE_W),
      .RESET_PERIOD (RESET_PERIOD)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .req        (req),
      .capture_in (capture_in[g]),
      .rdata      (ch_rdata[g]),
      .irq        (irq_vec[g])
    );
  end

  // channel indices with no instance fall through to zero
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (ch_idx == CH_AW'(i)) rd_mux = ch_rdata[i];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

  assign irq = |irq_vec;

endmodule

// File: tb/tb_multi_channel_interval_timer.sv
// Directed table-driven and sequence checks for multi_channel_interval_timer.
module tb_multi_channel_interval_timer;

  // five channels gives a 3-bit channel field, so index 5 addresses an absent channel
  localparam int NUM_CH = 5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [NUM_CH-1:0] capture_in = '0;
  logic [NUM_CH-1:0] irq_vec;
  logic        irq;

  multi_channel_interval_timer #(.NUM_CH(NUM_CH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .capture_in (capture_in),
    .irq_vec    (irq_vec),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic bus_wr(input int ch, input int off, input logic [31:0] d);
    @(negedge clk);
    address = {3'(ch), 3'(off)}; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_rd(input int ch, input int off, output logic [31:0] d);
    @(negedge clk);
    address = {3'(ch), 3'(off)}; chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
    d = readdata;
    chipselect = 1'b0;
  endtask

  typedef struct {
    bit          we;
    int          ch;
    int          off;
    logic [31:0] data;   // write data, or expected read data
    string       name;
  } vec_t;

  vec_t tbl[17];
  logic [31:0] d;
  int k_hit, t0;
  int tev[6];

  initial begin
    tbl[0]  = '{1'b0, 0, 2, 32'h000124F7, "rst_period0"};
    tbl[1]  = '{1'b0, 0, 0, 32'h0,        "rst_status0"};
    tbl[2]  = '{1'b0, 0, 1, 32'h0,        "rst_control0"};
    tbl[3]  = '{1'b0, 0, 3, 32'h0,        "rst_snapshot0"};
    tbl[4]  = '{1'b0, 0, 4, 32'h0,        "rst_capture0"};
    tbl[5]  = '{1'b0, 0, 5, 32'h0,        "rst_prescale0"};
    tbl[6]  = '{1'b0, 4, 2, 32'h000124F7, "rst_period4"};
    tbl[7]  = '{1'b0, 5, 2, 32'h0,        "absent_ch_period"};
    tbl[8]  = '{1'b0, 0, 6, 32'h0,        "reserved_off6"};
    tbl[9]  = '{1'b1, 3, 5, 32'h000001FF, ""};
    tbl[10] = '{1'b0, 3, 5, 32'h000000FF, "prescale_trunc"};
    tbl[11] = '{1'b1, 3, 1, 32'h000000F3, ""};
    tbl[12] = '{1'b0, 3, 1, 32'h00000033, "control_stored_bits"};
    tbl[13] = '{1'b0, 3, 0, 32'h0,        "status_no_start"};
    tbl[14] = '{1'b1, 3, 1, 32'h0,        ""};
    tbl[15] = '{1'b1, 3, 5, 32'h0,        ""};
    tbl[16] = '{1'b0, 3, 5, 32'h0,        "prescale_restore"};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_irq_vec", {27'b0, irq_vec}, 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      if (tbl[i].we) bus_wr(tbl[i].ch, tbl[i].off, tbl[i].data);
      else begin
        bus_rd(tbl[i].ch, tbl[i].off, d);
        check(tbl[i].name, d, tbl[i].data);
      end
    end

    // one-shot: period 5, no prescale -> TO six edges after the START edge
    bus_wr(0, 2, 32'd5);
    bus_wr(0, 5, 32'd0);
    bus_wr(0, 1, 32'h05);
    check("oneshot_irq_low", {31'b0, irq}, 32'h0);
    k_hit = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (irq) begin k_hit = k; break; end
    end
    check("oneshot_latency", k_hit, 32'd6);
    bus_rd(0, 0, d);
    check("oneshot_status", d, 32'h1);
    bus_wr(0, 0, 32'h1);
    check("to_clear_irq", {31'b0, irq}, 32'h0);
    bus_wr(0, 3, 32'h0);
    bus_rd(0, 3, d);
    check("oneshot_reload", d, 32'd5);

    // continuous with prescale: (2+1)*(3+1) = 12 clocks per timeout
    bus_wr(1, 2, 32'd2);
    bus_wr(1, 5, 32'd3);
    bus_wr(1, 1, 32'h07);
    t0 = cyc;
    for (int e = 0; e < 6; e++) begin
      tev[e] = 0;
      for (int k = 0; k < 40; k++) begin
        if (irq_vec[1]) begin tev[e] = cyc; break; end
        @(negedge clk);
      end
      bus_wr(1, 0, 32'h1);
    end
    check("cont_first", tev[0] - t0, 32'd9);
    for (int e = 1; e < 6; e++) check($sformatf("cont_period%0d", e), tev[e] - tev[e-1], 32'd12);
    bus_wr(1, 1, 32'h08);
    repeat (10) @(negedge clk);
    bus_rd(1, 0, d);
    check("stop_status", d, 32'h0);
    bus_wr(1, 3, 32'h0);
    bus_rd(1, 3, d);
    check("stop_frozen", d, 32'd2);
    bus_rd(1, 1, d);
    check("stop_control", d, 32'h0);

    // capture on ch2: CAP visible three edges after the input edge
    bus_wr(2, 1, 32'h34);
    capture_in[2] = 1'b1;
    repeat (2) @(negedge clk);
    check("cap_not_early", {31'b0, irq_vec[2]}, 32'h0);
    @(negedge clk);
    check("cap_latency", {27'b0, irq_vec}, 32'h4);
    capture_in[2] = 1'b0;
    bus_rd(2, 4, d);
    check("capture_value", d, 32'h000124F5);
    bus_rd(2, 0, d);
    check("cap_status", d, 32'h6);
    bus_rd(2, 1, d);
    check("cap_control", d, 32'h30);
    bus_wr(2, 0, 32'h4);
    check("cap_clear", {27'b0, irq_vec}, 32'h0);

    // status clear lands on the same edge as the timeout event
    bus_wr(0, 1, 32'h05);
    bus_wr(0, 0, 32'h1);
    bus_wr(0, 0, 32'h1);
    bus_wr(0, 0, 32'h1);
    bus_rd(0, 0, d);
    check("collision_to_kept", d, 32'h1);
    bus_wr(0, 0, 32'h1);
    check("collision_clear", {31'b0, irq}, 32'h0);

    bus_wr(4, 1, 32'h0C);
    bus_rd(4, 0, d);
    check("start_wins_stop", d, 32'h2);
    bus_wr(4, 2, 32'h40);
    bus_wr(4, 3, 32'h0);
    bus_rd(4, 3, d);
    check("period_wr_reload", d, 32'h40);
    bus_rd(4, 0, d);
    check("period_wr_stops", d, 32'h0);

    bus_wr(3, 1, 32'h04);
    bus_wr(3, 3, 32'h0);
    bus_rd(3, 3, d);
    check("snapshot_running", d, 32'h000124F6);

    bus_wr(5, 2, 32'h77);
    bus_wr(5, 1, 32'h04);
    bus_rd(5, 2, d);
    check("absent_period", d, 32'h0);
    bus_rd(5, 0, d);
    check("absent_status", d, 32'h0);
    bus_rd(4, 2, d);
    check("absent_no_alias", d, 32'h40);
    check("absent_irq", {27'b0, irq_vec}, 32'h0);

    // asynchronous reset mid-count
    bus_rd(4, 2, d);
    #1 reset_n = 1'b0;
    #1 check("async_rst_readdata", readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    bus_rd(3, 0, d);
    check("async_rst_status3", d, 32'h0);
    bus_rd(3, 3, d);
    check("async_rst_snapshot3", d, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
